uart_arbiter: RTL and testbench

//  Shares a single uart_com byte link between two 32-bit memory requesters (port 0: instruction

---
 rtl/uart_arbiter_if.sv | 44 ++++
 rtl/uart_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_arbiter_if.sv
// Request/response and uart_com FIFO signals shared by the two requesters and the arbiter.
// slave: arbiter view; master: requester/uart_com environment view.
interface uart_arbiter_if;
  logic        req0_valid;
  logic        req0_we;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_done;
  logic [31:0] req0_rdata;
  logic        req0_err;

  logic        req1_valid;
  logic        req1_we;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_done;
  logic [31:0] req1_rdata;
  logic        req1_err;

  logic        uart_send_flag;
  logic [7:0]  uart_send_data;
  logic        uart_sendable;
  logic        uart_recv_flag;
  logic [7:0]  uart_recv_data;
  logic        uart_receivable;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_done, req1_rdata, req1_err,
    output uart_send_flag, uart_send_data, uart_recv_flag,
    input  uart_sendable, uart_recv_data, uart_receivable
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_done, req0_rdata, req0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_done, req1_rdata, req1_err,
    input  uart_send_flag, uart_send_data, uart_recv_flag,
    output uart_sendable, uart_recv_data, uart_receivable
  );
endinterface

// File: rtl/uart_arbiter.sv
// Two-port memory request arbiter over a shared uart_com byte link.
// Each request is serialised as header + 4 address bytes (+ 4 write bytes),
// reads collect a 4-byte LSB-first response.
// Optional read-response watchdog: define UART_ARB_TIMEOUT_EN.
module uart_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           rst,
  uart_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        port_q;
  logic        we_q;
  logic        last_grant_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  idx_q;
  logic [23:0] rbuf_q;
  logic        done0_q;
  logic        done1_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        grant_d;
  logic        send_st;
  logic [7:0]  send_byte;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        err0_q;
  logic        err1_q;
`endif

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Round-robin winner: contention goes to the port not served last.
  assign grant_d = (bus.req0_valid && bus.req1_valid) ? !last_grant_q : bus.req1_valid;

  // Byte currently offered to the send FIFO.
  always_comb begin
    send_byte = 8'h00;
    case (state_q)
      S_HDR:   send_byte = {port_q, we_q, 6'b000000};
      S_ADDR:  send_byte = byte_sel(addr_q, idx_q);
      S_WDATA: send_byte = byte_sel(wdata_q, idx_q);
      default: send_byte = 8'h00;
    endcase
  end

  // FIFO strobes must qualify with same-cycle FIFO status, so they decode registered state directly.
  assign send_st             = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign bus.uart_send_flag  = rst && send_st && bus.uart_sendable;
  assign bus.uart_send_data  = send_byte;
  assign bus.uart_recv_flag  = rst && ((state_q == S_IDLE) || (state_q == S_RESP)) && bus.uart_receivable;

  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign bus.req0_err = err0_q;
  assign bus.req1_err = err1_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus.req0_err = 1'b0;
  assign bus.req1_err = 1'b0;
`endif

  // Packet sequencer: grant, push header/address/data, collect response, pulse done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= 2'd0;
      rbuf_q       <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q         <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      if (state_q != S_RESP) wd_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          // A stray receive byte is drained first; grant waits for an empty receive FIFO.
          if (!bus.uart_receivable && (bus.req0_valid || bus.req1_valid)) begin
            port_q       <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= grant_d ? bus.req1_we    : bus.req0_we;
            addr_q       <= grant_d ? bus.req1_addr  : bus.req0_addr;
            wdata_q      <= grant_d ? bus.req1_wdata : bus.req0_wdata;
            idx_q        <= 2'd0;
            state_q      <= S_HDR;
          end
        end
        S_HDR: begin
          if (bus.uart_sendable) state_q <= S_ADDR;
        end
        S_ADDR: begin
          if (bus.uart_sendable) begin
            idx_q <= 2'(idx_q + 2'd1);
            if (idx_q == 2'd3) state_q <= we_q ? S_WDATA : S_RESP;
          end
        end
        S_WDATA: begin
          if (bus.uart_sendable) begin
            idx_q <= 2'(idx_q + 2'd1);
            if (idx_q == 2'd3) begin
              state_q <= S_DONE;
              done0_q <= !port_q;
              done1_q <= port_q;
            end
          end
        end
        S_RESP: begin
          if (bus.uart_receivable) begin
            idx_q <= 2'(idx_q + 2'd1);
`ifdef UART_ARB_TIMEOUT_EN
            wd_q  <= '0;
`endif
            case (idx_q)
              2'd0: rbuf_q[7:0]   <= bus.uart_recv_data;
              2'd1: rbuf_q[15:8]  <= bus.uart_recv_data;
              2'd2: rbuf_q[23:16] <= bus.uart_recv_data;
              default: begin
                state_q <= S_DONE;
                done0_q <= !port_q;
                done1_q <= port_q;
                if (port_q) rdata1_q <= {bus.uart_recv_data, rbuf_q};
                else        rdata0_q <= {bus.uart_recv_data, rbuf_q};
              end
            endcase
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_DONE;
            done0_q <= !port_q;
            done1_q <= port_q;
            err0_q  <= !port_q;
            err1_q  <= port_q;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
`endif
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: vector table of single transactions plus
// hand-written arbitration, stray-drain, reset and (optional) timeout sequences.
module tb_uart_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_arbiter_if ifc ();

`ifdef UART_ARB_TIMEOUT_EN
  uart_arbiter #(.TIMEOUT_CYCLES(50)) dut (.clk(clk), .rst(rst), .bus(ifc));
`else
  uart_arbiter dut (.clk(clk), .rst(rst), .bus(ifc));
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] push_q[$];
  logic [7:0] rq[$];
  int         pops;
  int         bad_strobe;
  int         done0_n;
  int         done1_n;
  logic       bp_pat[4];

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic        bp;
    logic [7:0]  hdr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // uart_com model: receive FIFO head driven on negedge, strobes sampled 1 ns later.
  initial begin
    logic pop_pend;
    pop_pend = 1'b0;
    pops = 0; bad_strobe = 0; done0_n = 0; done1_n = 0;
    ifc.uart_receivable = 1'b0;
    ifc.uart_recv_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (pop_pend && rq.size() > 0) void'(rq.pop_front());
      pop_pend = 1'b0;
      ifc.uart_receivable = (rq.size() > 0);
      ifc.uart_recv_data  = (rq.size() > 0) ? rq[0] : 8'h00;
      #1;
      if (ifc.uart_send_flag === 1'b1) begin
        if (ifc.uart_sendable) push_q.push_back(ifc.uart_send_data);
        else bad_strobe++;
      end
      if (ifc.uart_recv_flag === 1'b1) begin
        if (ifc.uart_receivable) begin pop_pend = 1'b1; pops++; end
        else bad_strobe++;
      end
      if (ifc.req0_done === 1'b1) done0_n++;
      if (ifc.req1_done === 1'b1) done1_n++;
    end
  end

  task automatic clear_logs();
    push_q.delete();
    pops = 0; done0_n = 0; done1_n = 0;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] rd0, input logic [31:0] rd1);
    check({tag, "_done0"}, 32'(ifc.req0_done), 0);
    check({tag, "_done1"}, 32'(ifc.req1_done), 0);
    check({tag, "_err0"},  32'(ifc.req0_err), 0);
    check({tag, "_err1"},  32'(ifc.req1_err), 0);
    check({tag, "_sflag"}, 32'(ifc.uart_send_flag), 0);
    check({tag, "_rflag"}, 32'(ifc.uart_recv_flag), 0);
    check({tag, "_sdata"}, 32'(ifc.uart_send_data), 0);
    check({tag, "_rdata0"}, ifc.req0_rdata, rd0);
    check({tag, "_rdata1"}, ifc.req1_rdata, rd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int         cnt;
    bit         seen, loaded;
    logic [31:0] rd;
    logic       er;
    logic [7:0] exp_b[9];
    int         n;
    @(negedge clk); #2;
    clear_logs();
    if (v.port) begin
      ifc.req1_valid = 1'b1; ifc.req1_we = v.we; ifc.req1_addr = v.addr; ifc.req1_wdata = v.wdata;
    end else begin
      ifc.req0_valid = 1'b1; ifc.req0_we = v.we; ifc.req0_addr = v.addr; ifc.req0_wdata = v.wdata;
    end
    cnt = 0; seen = 1'b0; loaded = 1'b0; rd = '0; er = 1'b0;
    while (!seen && cnt < 300) begin
      @(negedge clk);
      ifc.uart_sendable = v.bp ? bp_pat[cnt % 4] : 1'b1;
      #2;
      cnt++;
      if (!v.we && !loaded && push_q.size() >= 5) begin
        for (int k = 0; k < 4; k++) rq.push_back(v.resp[8*k +: 8]);
        loaded = 1'b1;
      end
      if ((v.port ? ifc.req1_done : ifc.req0_done) === 1'b1) begin
        seen = 1'b1;
        rd = v.port ? ifc.req1_rdata : ifc.req0_rdata;
        er = v.port ? ifc.req1_err : ifc.req0_err;
      end
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    ifc.uart_sendable = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    $display("vector %0d: port=%0d we=%0d cycles=%0d", id, v.port, v.we, cnt);
    check("done_seen", 32'(seen), 1);
    // cnt counts negedges after valid; the grant cycle is cycle 1, so done in cycle 11 shows as cnt 10
    if (!v.bp && v.we) check("write_latency", cnt, 10);
    check("done_pulses", v.port ? done1_n : done0_n, 1);
    check("other_done", v.port ? done0_n : done1_n, 0);
    n = v.we ? 9 : 5;
    check("push_count", push_q.size(), n);
    exp_b[0] = v.hdr;
    for (int k = 0; k < 4; k++) begin
      exp_b[1+k] = v.addr[8*k +: 8];
      exp_b[5+k] = v.wdata[8*k +: 8];
    end
    for (int k = 0; k < n; k++)
      check($sformatf("byte%0d", k), (k < push_q.size()) ? 32'(push_q[k]) : 32'hFFFF_FFFF, 32'(exp_b[k]));
    check("rdata", rd, v.exp_rdata);
    check("err", 32'(er), 0);
    check("pops", pops, v.we ? 0 : 4);
  endtask

  initial begin
    int          cnt;
    int          dt[$];
    bit          ok;
    int          base;
    rst = 1'b0;
    ifc.req0_valid = 1'b0; ifc.req0_we = 1'b0; ifc.req0_addr = '0; ifc.req0_wdata = '0;
    ifc.req1_valid = 1'b0; ifc.req1_we = 1'b0; ifc.req1_addr = '0; ifc.req1_wdata = '0;
    ifc.uart_sendable = 1'b1;
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;

    //            port  we    addr          wdata         resp          bp    hdr    exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0,        1'b0, 8'h40, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 8'h80, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'hA5A5_0F0F, 32'h0102_0304, 32'h0,        1'b1, 8'hC0, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D, 1'b1, 8'h00, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0,         32'h0,         32'h0,        1'b0, 8'h40, 32'hCAFE_F00D};

    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Stray bytes in IDLE: drained, no completion, results untouched.
    @(negedge clk); #2;
    clear_logs();
    rq.push_back(8'h11); rq.push_back(8'h22); rq.push_back(8'h33);
    repeat (8) @(negedge clk);
    #2;
    check("stray_pops", pops, 3);
    check("stray_left", rq.size(), 0);
    check("stray_done", done0_n + done1_n, 0);
    check("stray_push", push_q.size(), 0);
    check_idle_outputs("stray", 32'hCAFE_F00D, 32'h1234_5678);

    // Reset again, then both ports contend continuously.
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    check_idle_outputs("rst2", 32'h0, 32'h0);
    clear_logs();
    ifc.req0_valid = 1'b1; ifc.req0_we = 1'b1; ifc.req0_addr = 32'h0000_0100; ifc.req0_wdata = 32'h1111_1111;
    ifc.req1_valid = 1'b1; ifc.req1_we = 1'b1; ifc.req1_addr = 32'h0000_0200; ifc.req1_wdata = 32'h2222_2222;
    cnt = 0;
    while (dt.size() < 4 && cnt < 200) begin
      @(negedge clk); #2;
      cnt++;
      if (ifc.req0_done === 1'b1 || ifc.req1_done === 1'b1) dt.push_back(cnt);
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("arb_dones", dt.size(), 4);
    if (dt.size() == 4) begin
      check("arb_first_done", dt[0], 10);
      check("arb_spacing", dt[1] - dt[0], 11);
    end
    check("arb_done0", done0_n, 2);
    check("arb_done1", done1_n, 2);
    check("arb_push_count", push_q.size(), 36);
    if (push_q.size() == 36) begin
      check("arb_grant0", 32'(push_q[0]),  32'h40);
      check("arb_grant1", 32'(push_q[9]),  32'hC0);
      check("arb_grant2", 32'(push_q[18]), 32'h40);
      check("arb_grant3", 32'(push_q[27]), 32'hC0);
    end

    // Reset while the third address byte is pending.
    @(negedge clk); #2;
    clear_logs();
    ifc.req0_valid = 1'b1; ifc.req0_we = 1'b1; ifc.req0_addr = 32'h8765_4321; ifc.req0_wdata = 32'h5555_AAAA;
    cnt = 0;
    while (push_q.size() < 3 && cnt < 50) begin
      @(negedge clk); #2;
      cnt++;
    end
    check("rstmid_reach", 32'(push_q.size()), 3);
    @(negedge clk);
    rst = 1'b0;
    ifc.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_idle_outputs("rstmid", 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    #2;
    check("rstmid_pushes", push_q.size(), 3);
    if (push_q.size() == 3) check("rstmid_last_byte", 32'(push_q[2]), 32'h43);
    check("rstmid_done", done0_n + done1_n, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Read with no response: watchdog completes it with err after 50 cycles in RESP.
    @(negedge clk); #2;
    clear_logs();
    ifc.req0_valid = 1'b1; ifc.req0_we = 1'b0; ifc.req0_addr = 32'h0000_0020;
    cnt = 0;
    while (push_q.size() < 5 && cnt < 50) begin
      @(negedge clk); #2;
      cnt++;
    end
    cnt = 0; ok = 1'b0;
    while (!ok && cnt < 200) begin
      @(negedge clk); #2;
      cnt++;
      if (ifc.req0_done === 1'b1) begin
        ok = 1'b1;
        check("to_err", 32'(ifc.req0_err), 1);
        check("to_rdata", ifc.req0_rdata, 32'h0);
      end
    end
    ifc.req0_valid = 1'b0;
    check("to_seen", 32'(ok), 1);
    check("to_cycles", cnt, 51);
    repeat (3) @(negedge clk);
    #2;
    check("to_done_pulses", done0_n, 1);
`endif

    base = bad_strobe;
    check("strobe_protocol", base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
